ps2_key_rx: RTL and testbench

Receive-only PS/2 keyboard front end that turns the raw keyboard clock/data lines into the 11-bit `ps2_key` event word consumed by the Ondra core's keyboard matrix. It sits directly upstream of the core's `ps2_key` input. It synchronises and deglitches both lines, deframes 11-bit PS/2 frames, checks parity and stop bit, and folds the E0/F0/E1 prefixes into one event per key press or release.

---
 rtl/ps2_key_rx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: receive-only PS/2 keyboard front end.
// Synchronises and deglitches the raw PS/2 clock/data lines, deframes 11-bit
// frames (start, 8 data LSB first, odd parity, stop), and folds E0/F0/E1
// prefixes into one event word per key press or release.
//
// Ports:
//   clk_sys     - system clock (8 MHz), the only clock
//   reset_n     - asynchronous active-low reset
//   ps2_clk     - raw keyboard clock (asynchronous)
//   ps2_dat     - raw keyboard data (asynchronous)
//   ps2_key     - event word: [10] toggle, [9] make, [8] E0-extended, [7:0] scancode
//   rx_error    - one-cycle pulse on parity, stop-bit or timeout error
//   byte_strobe - one-cycle pulse for each good byte, prefixes included
//   byte_data   - last good byte, held after byte_strobe
module ps2_key_rx #(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 8000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] ps2_key,
  output logic        rx_error,
  output logic        byte_strobe,
  output logic [7:0]  byte_data
);

  localparam int unsigned FW = (FILTER  > 1) ? $clog2(FILTER)  : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // ---------------- input conditioning ----------------
  // Bit 0 carries the clock line, bit 1 the data line.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_filt_d;
  logic          tick;

  assign raw = {ps2_dat, ps2_clk};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= '1;
      sync2      <= '1;
      filt       <= '1;
      clk_filt_d <= 1'b1;
      tick       <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      clk_filt_d <= filt[0];
      tick       <= clk_filt_d & ~filt[0];
      // The filtered level follows only on the FILTER-th consecutive
      // differing sample; any agreeing sample restarts the count.
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (fcnt[i] == FW'(FILTER - 1)) begin
            filt[i] <= sync2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  // ---------------- frame state machine ----------------
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t        state, state_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [8:0]    shreg, shreg_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          err_n, strobe_n;
  logic [7:0]    data_n;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tcnt        <= '0;
      rx_error    <= 1'b0;
      byte_strobe <= 1'b0;
      byte_data   <= '0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      tcnt        <= tcnt_n;
      rx_error    <= err_n;
      byte_strobe <= strobe_n;
      byte_data   <= data_n;
    end
  end

  // The frame verdict is evaluated on the stop-bit tick itself so that the
  // registered strobe/error/data coincide with the single CHECK cycle.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tcnt_n    = tcnt;
    err_n     = 1'b0;
    strobe_n  = 1'b0;
    data_n    = byte_data;
    unique case (state)
      IDLE: begin
        tcnt_n = '0;
        if (tick && !filt[1]) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          tcnt_n = '0;
          if (bit_cnt == 4'd9) begin
            state_n = CHECK;
            if ((^shreg) && filt[1]) begin
              strobe_n = 1'b1;
              data_n   = shreg[7:0];
            end else begin
              err_n = 1'b1;
            end
          end else begin
            shreg_n   = {filt[1], shreg[8:1]};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
          tcnt_n  = '0;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      CHECK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------- event decoder ----------------
  logic       ext;
  logic       brk;
  logic [2:0] pause_skip;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key    <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      pause_skip <= '0;
    end else if (byte_strobe) begin
      if (pause_skip != 3'd0) begin
        pause_skip <= pause_skip - 3'd1;
      end else begin
        case (byte_data)
          8'hE1: pause_skip <= 3'd7;
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
          end
          default: begin
            ps2_key <= {~ps2_key[10], ~brk, ext, byte_data};
            ext     <= 1'b0;
            brk     <= 1'b0;
          end
        endcase
      end
    end else if (rx_error) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: directed frames with a scoreboard of
// expected bytes, events and errors, consumed as the DUT produces them.
`timescale 1ns/1ns
module tb_ps2_key_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 8000;
  localparam int HP_SLOW = 320;  // 12.5 kHz half period at 8 MHz
  localparam int HP_FAST = 40;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        rx_error;
  logic        byte_strobe;
  logic [7:0]  byte_data;

  ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .ps2_key(ps2_key), .rx_error(rx_error), .byte_strobe(byte_strobe),
    .byte_data(byte_data)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int stop_cyc = 0;
  int last_fall_cyc = 0;
  int exp_errs = 0;
  logic [7:0]  exp_bytes[$];
  logic [10:0] exp_keys[$];
  logic [10:0] prev_key;
  logic [10:0] m_key;
  logic        m_ext, m_brk;
  int          m_skip;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Reference decoder: updates the expectations for one received frame.
  task automatic model_byte(input logic [7:0] b, input logic good);
    if (!good) begin
      exp_errs++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      exp_bytes.push_back(b);
      if (m_skip != 0) m_skip--;
      else if (b == 8'hE1) m_skip = 7;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
        m_key = {~m_key[10], ~m_brk, m_ext, b};
        exp_keys.push_back(m_key);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  // Drives the first nticks bits of a frame; data changes mid-high phase.
  task automatic frame(input logic [7:0] b, input int hp, input logic bad_par, input int nticks);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nticks; i++) begin
      ps2_dat = f[i];
      wait_cyc(hp / 2);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(hp);
      ps2_clk = 1'b1;
      wait_cyc(hp / 2);
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par, input int hp);
    model_byte(b, !bad_par);
    frame(b, hp, bad_par, 11);
    wait_cyc(40);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    m_key = '0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(5);
  endtask

  initial begin
    int n;
    m_key = '0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    prev_key = '0;

    fork
      forever begin
        @(negedge clk_sys);
        if (!reset_n) begin
          prev_key = ps2_key;
        end else begin
          if (byte_strobe) begin
            chk("strobe_err_excl", {31'd0, rx_error}, 0);
            chk("byte_avail", {31'd0, exp_bytes.size() != 0}, 1);
            if (exp_bytes.size() != 0) chk("byte_data", {24'd0, byte_data}, {24'd0, exp_bytes.pop_front()});
          end
          if (rx_error) begin
            chk("err_expected", {31'd0, exp_errs != 0}, 1);
            if (exp_errs > 0) exp_errs--;
          end
          if (ps2_key !== prev_key) begin
            chk("key_avail", {31'd0, exp_keys.size() != 0}, 1);
            if (exp_keys.size() != 0) chk("key_value", {21'd0, ps2_key}, {21'd0, exp_keys.pop_front()});
            chk("key_latency", cyc - stop_cyc, FILTER + 5);
            prev_key = ps2_key;
          end
        end
      end
    join_none

    // Reset state
    wait_cyc(3);
    chk("rst_key", {21'd0, ps2_key}, 0);
    chk("rst_err", {31'd0, rx_error}, 0);
    chk("rst_strobe", {31'd0, byte_strobe}, 0);
    chk("rst_data", {24'd0, byte_data}, 0);
    reset_n = 1'b1;
    wait_cyc(5);

    // Plain make at 12.5 kHz
    send(8'h1C, 1'b0, HP_SLOW);
    chk("plain_make", {21'd0, ps2_key}, 11'h61C);

    // Extended break, then a plain make
    do_reset();
    send(8'hE0, 1'b0, HP_FAST);
    send(8'hF0, 1'b0, HP_FAST);
    chk("prefix_no_event", {21'd0, ps2_key}, 0);
    send(8'h75, 1'b0, HP_FAST);
    chk("ext_break", {21'd0, ps2_key}, 11'h575);
    send(8'h1C, 1'b0, HP_FAST);
    chk("make_after_ext", {21'd0, ps2_key}, 11'h21C);

    // Parity error clears the prefix
    do_reset();
    send(8'hE0, 1'b0, HP_FAST);
    send(8'h1C, 1'b1, HP_FAST);
    chk("parity_no_event", {21'd0, ps2_key}, 0);
    send(8'h1C, 1'b0, HP_FAST);
    chk("after_parity", {21'd0, ps2_key}, 11'h61C);

    // Timeout on a partial frame
    do_reset();
    exp_errs++;
    m_ext = 1'b0; m_brk = 1'b0;
    frame(8'h1C, HP_FAST, 1'b0, 5);
    n = 0;
    while (!rx_error && n < 9000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("timeout_seen", {31'd0, rx_error}, 1);
    chk("timeout_cycles", cyc - last_fall_cyc, FILTER + 4 + TIMEOUT);
    wait_cyc(10);
    send(8'h1C, 1'b0, HP_FAST);
    chk("after_timeout", {21'd0, ps2_key}, 11'h61C);

    // Pause sequence and controller responses
    do_reset();
    send(8'hE1, 1'b0, HP_FAST); send(8'h14, 1'b0, HP_FAST);
    send(8'h77, 1'b0, HP_FAST); send(8'hE1, 1'b0, HP_FAST);
    send(8'hF0, 1'b0, HP_FAST); send(8'h14, 1'b0, HP_FAST);
    send(8'hF0, 1'b0, HP_FAST); send(8'h77, 1'b0, HP_FAST);
    chk("pause_no_event", {21'd0, ps2_key}, 0);
    send(8'hAA, 1'b0, HP_FAST);
    chk("response_no_event", {21'd0, ps2_key}, 0);
    send(8'h29, 1'b0, HP_FAST);
    chk("after_pause", {21'd0, ps2_key}, 11'h629);

    // 5-cycle clock glitch with data low must not start a frame
    ps2_dat = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(20);
    ps2_dat = 1'b1;
    wait_cyc(20);
    send(8'h1C, 1'b0, HP_FAST);
    chk("after_glitch", {21'd0, ps2_key}, 11'h21C);

    // Reset in the middle of a frame
    frame(8'h1C, HP_FAST, 1'b0, 7);
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    m_key = '0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    #1;
    chk("midrst_key", {21'd0, ps2_key}, 0);
    chk("midrst_data", {24'd0, byte_data}, 0);
    chk("midrst_strobe", {31'd0, byte_strobe}, 0);
    chk("midrst_err", {31'd0, rx_error}, 0);
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(20);
    send(8'h1C, 1'b0, HP_FAST);
    chk("after_midrst", {21'd0, ps2_key}, 11'h61C);

    wait_cyc(50);
    chk("bytes_drained", exp_bytes.size(), 0);
    chk("keys_drained", exp_keys.size(), 0);
    chk("errs_drained", exp_errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
